// File: rtl/prim_secded_28_22_enc_buf.sv
// SECDED (28,22) write-path encoder feeding a 2-entry valid/ready output buffer,
// with one-shot XOR fault injection and a saturating delivered-word counter.
module prim_secded_28_22_enc_buf #(
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [21:0]         in_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [27:0]         out_data_o,
  input  logic                inj_req_i,
  input  logic [27:0]         inj_mask_i,
  output logic                inj_pending_o,
  output logic [CntWidth-1:0] word_cnt_o
);

  localparam int unsigned DataW  = 22;
  localparam int unsigned CheckW = 6;
  localparam int unsigned CodeW  = DataW + CheckW;
  localparam int unsigned OccW   = 2;

  logic [CodeW-1:0]    r_mem [2];
  logic                r_wptr;
  logic                r_rptr;
  logic [OccW-1:0]     r_count;
  logic                r_inj_pending;
  logic [CodeW-1:0]    r_inj_mask;
  logic [CntWidth-1:0] r_word_cnt;

  logic [CheckW-1:0]   w_check;
  logic [CodeW-1:0]    w_code;
  logic                w_push;
  logic                w_pop;

  // Check-bit generation: each bit is the parity of a fixed data subset
  always_comb begin
    w_check    = '0;
    w_check[0] = ^{in_data_i[21:20], in_data_i[9:0]};
    w_check[1] = ^{in_data_i[21:20], in_data_i[15:10], in_data_i[3:0]};
    w_check[2] = ^{in_data_i[20], in_data_i[18:16], in_data_i[12:10],
                   in_data_i[6:4], in_data_i[0]};
    w_check[3] = ^{in_data_i[21], in_data_i[19], in_data_i[17:16],
                   in_data_i[14:13], in_data_i[10], in_data_i[8:7],
                   in_data_i[4], in_data_i[1]};
    w_check[4] = ^{in_data_i[21:18], in_data_i[16:15], in_data_i[13],
                   in_data_i[11], in_data_i[9], in_data_i[7],
                   in_data_i[5], in_data_i[2]};
    w_check[5] = ^{in_data_i[21:17], in_data_i[15:14], in_data_i[12],
                   in_data_i[9:8], in_data_i[6], in_data_i[3]};
    w_code     = {w_check, in_data_i};
  end

  // Ready/valid decode only from registered occupancy, so no ready->ready path
  assign in_ready_o    = (r_count != OccW'(2));
  assign out_valid_o   = (r_count != OccW'(0));
  assign w_push        = in_valid_i && in_ready_o;
  assign w_pop         = out_valid_o && out_ready_i;
  assign out_data_o    = out_valid_o ? r_mem[r_rptr] : '0;
  assign inj_pending_o = r_inj_pending;
  assign word_cnt_o    = r_word_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_code ^ (r_inj_pending ? r_inj_mask : '0);
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OccW'(1);
        2'b01:   r_count <= r_count - OccW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A pending mask is consumed by the next push; a request while armed is dropped
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_inj_pending <= 1'b0;
      r_inj_mask    <= '0;
    end else if (r_inj_pending) begin
      if (w_push) begin
        r_inj_pending <= 1'b0;
        r_inj_mask    <= '0;
      end
    end else if (inj_req_i) begin
      r_inj_pending <= 1'b1;
      r_inj_mask    <= inj_mask_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_word_cnt <= '0;
    end else if (w_pop && (r_word_cnt != {CntWidth{1'b1}})) begin
      r_word_cnt <= r_word_cnt + CntWidth'(1);
    end
  end

endmodule
